// File: rtl/stopwatch_core.sv
// stopwatch_core: hh:mm:ss.cc up/down counter with split freeze,
// lap buffer and preset load, ticking every 10 ms of clk.
module stopwatch_core #(
  parameter int CLK_HZ    = 100000000,
  parameter int LAP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_p,
  input  logic                         stop_p,
  input  logic                         split_p,
  input  logic                         clear_p,
  input  logic                         mode_down,
  input  logic                         load_p,
  input  logic [23:0]                  load_bcd,
  output logic [31:0]                  time_bcd,
  output logic [31:0]                  disp_bcd,
  output logic                         running,
  output logic                         frozen,
  output logic                         expired,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_ovf,
  input  logic [$clog2(LAP_DEPTH)-1:0] lap_rd_idx,
  output logic [31:0]                  lap_rd_data
);

  localparam int DIV = CLK_HZ / 100;
  localparam int PW  = $clog2(DIV);
  localparam int AW  = $clog2(LAP_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] LAP_MAX = CW'(LAP_DEPTH);

  // Per-digit maximum, hr_t down to cs_o.
  localparam logic [31:0] LIM = 32'h9959_5999;

  typedef enum logic [2:0] {
    C_NONE,
    C_CLEAR,
    C_LOAD,
    C_STOP,
    C_START,
    C_SPLIT
  } cmd_e;

  function automatic logic [31:0] bcd_step(
    input logic [31:0] t,
    input logic        down
  );
    logic [31:0] r;
    logic [3:0]  d;
    logic [3:0]  lim;
    logic        c;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d   = t[i*4 +: 4];
      lim = LIM[i*4 +: 4];
      if (c) begin
        if (!down) begin
          c = (d == lim);
          d = c ? 4'd0 : d + 4'd1;
        end else begin
          c = (d == 4'd0);
          d = c ? lim : d - 4'd1;
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic bcd_legal(
    input logic [23:0] b
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (b[i*4 +: 4] > LIM[8 + i*4 +: 4])
        ok = 1'b0;
    end
    return ok;
  endfunction

  logic [PW-1:0] pre;
  logic          tick;
  logic [31:0]   nxt_time;
  logic          down_hit;
  logic          load_ok;
  logic          start_ok;
  logic          lap_full;
  logic          lap_we;
  logic [31:0]   frz_bcd;
  logic [31:0]   laps [LAP_DEPTH];
  cmd_e          cmd;

  assign tick     = running && (pre == PRE_MAX);
  assign nxt_time = bcd_step(time_bcd, mode_down);
  assign down_hit = mode_down && (nxt_time == 32'd0);
  assign load_ok  = !running && bcd_legal(load_bcd);
  assign start_ok = !running && !(mode_down && time_bcd == 32'd0);
  assign lap_full = (lap_count == LAP_MAX);

  always_comb begin
    cmd = C_NONE;
    if (clear_p)
      cmd = C_CLEAR;
    else if (load_p)
      cmd = C_LOAD;
    else if (stop_p)
      cmd = C_STOP;
    else if (start_p)
      cmd = C_START;
    else if (split_p)
      cmd = C_SPLIT;
  end

  assign lap_we = (cmd == C_SPLIT) && running
                  && !frozen && !lap_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre       <= '0;
      time_bcd  <= '0;
      frz_bcd   <= '0;
      running   <= 1'b0;
      frozen    <= 1'b0;
      expired   <= 1'b0;
      lap_count <= '0;
      lap_ovf   <= 1'b0;
    end else begin
      if (!running || tick)
        pre <= '0;
      else
        pre <= pre + PW'(1);

      // A tick in the same cycle as stop still lands.
      if (tick) begin
        time_bcd <= nxt_time;
        if (down_hit) begin
          running <= 1'b0;
          expired <= 1'b1;
        end
      end

      unique case (cmd)
        C_CLEAR: begin
          time_bcd  <= '0;
          running   <= 1'b0;
          frozen    <= 1'b0;
          expired   <= 1'b0;
          lap_count <= '0;
          lap_ovf   <= 1'b0;
        end
        C_LOAD: begin
          if (load_ok) begin
            time_bcd <= {load_bcd, 8'h00};
            expired  <= 1'b0;
          end
        end
        C_STOP: begin
          running <= 1'b0;
        end
        C_START: begin
          if (start_ok)
            running <= 1'b1;
        end
        C_SPLIT: begin
          if (frozen) begin
            frozen <= 1'b0;
          end else if (running) begin
            frz_bcd <= time_bcd;
            frozen  <= 1'b1;
            if (lap_full)
              lap_ovf <= 1'b1;
            else
              lap_count <= lap_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Entries above lap_count are masked on read, so no reset needed.
  always_ff @(posedge clk) begin
    if (lap_we)
      laps[lap_count[AW-1:0]] <= time_bcd;
  end

  assign disp_bcd    = frozen ? frz_bcd : time_bcd;
  assign lap_rd_data = ({1'b0, lap_rd_idx} < lap_count)
                       ? laps[lap_rd_idx] : 32'd0;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed and random stimulus against an
// integer-centisecond reference model of the stopwatch.
module tb_stopwatch_core;

  localparam int CLK_HZ    = 1000;
  localparam int LAP_DEPTH = 4;
  localparam int DIV       = CLK_HZ / 100;
  localparam int AW        = 2;
  localparam int CW        = 3;
  localparam int MAXT      = 36000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_p = 1'b0;
  logic          stop_p = 1'b0;
  logic          split_p = 1'b0;
  logic          clear_p = 1'b0;
  logic          mode_down = 1'b0;
  logic          load_p = 1'b0;
  logic [23:0]   load_bcd = '0;
  logic [31:0]   time_bcd;
  logic [31:0]   disp_bcd;
  logic          running;
  logic          frozen;
  logic          expired;
  logic [CW-1:0] lap_count;
  logic          lap_ovf;
  logic [AW-1:0] lap_rd_idx = '0;
  logic [31:0]   lap_rd_data;

  int checks = 0;
  int errors = 0;

  int m_t, m_cyc, m_fv;
  bit m_run, m_frz, m_exp, m_ovf;
  int m_laps[$];

  stopwatch_core #(
    .CLK_HZ   (CLK_HZ),
    .LAP_DEPTH(LAP_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_p    (start_p),
    .stop_p     (stop_p),
    .split_p    (split_p),
    .clear_p    (clear_p),
    .mode_down  (mode_down),
    .load_p     (load_p),
    .load_bcd   (load_bcd),
    .time_bcd   (time_bcd),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .frozen     (frozen),
    .expired    (expired),
    .lap_count  (lap_count),
    .lap_ovf    (lap_ovf),
    .lap_rd_idx (lap_rd_idx),
    .lap_rd_data(lap_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(int cs);
    int h, m, s, c;
    c = cs % 100;
    s = (cs / 100) % 60;
    m = (cs / 6000) % 60;
    h = cs / 360000;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic bit legal(logic [23:0] b);
    return b[23:20] <= 9 && b[19:16] <= 9 && b[15:12] <= 5
        && b[11:8] <= 9 && b[7:4] <= 5 && b[3:0] <= 9;
  endfunction

  function automatic int load_cs(logic [23:0] b);
    int h, m, s;
    h = int'(b[23:20]) * 10 + int'(b[19:16]);
    m = int'(b[15:12]) * 10 + int'(b[11:8]);
    s = int'(b[7:4]) * 10 + int'(b[3:0]);
    return ((h * 60 + m) * 60 + s) * 100;
  endfunction

  task automatic model_step();
    bit tick, nrun, nfrz, nexp, novf;
    int nt, nfv;
    if (reset) begin
      m_t = 0; m_cyc = 0; m_fv = 0;
      m_run = 0; m_frz = 0; m_exp = 0; m_ovf = 0;
      m_laps.delete();
      return;
    end
    tick = m_run && (m_cyc % DIV == DIV - 1);
    nt = m_t; nfv = m_fv;
    nrun = m_run; nfrz = m_frz; nexp = m_exp; novf = m_ovf;
    if (tick) begin
      if (!mode_down) begin
        nt = (m_t + 1) % MAXT;
      end else begin
        nt = (m_t == 0) ? MAXT - 1 : m_t - 1;
        if (nt == 0) begin
          nrun = 0;
          nexp = 1;
        end
      end
    end
    if (clear_p) begin
      nt = 0; nrun = 0; nfrz = 0; nexp = 0; novf = 0;
      m_laps.delete();
    end else if (load_p) begin
      if (!m_run && legal(load_bcd)) begin
        nt = load_cs(load_bcd);
        nexp = 0;
      end
    end else if (stop_p) begin
      nrun = 0;
    end else if (start_p) begin
      if (!m_run && !(mode_down && m_t == 0))
        nrun = 1;
    end else if (split_p) begin
      if (m_frz) begin
        nfrz = 0;
      end else if (m_run) begin
        nfrz = 1;
        nfv = m_t;
        if (m_laps.size() < LAP_DEPTH)
          m_laps.push_back(m_t);
        else
          novf = 1;
      end
    end
    m_cyc = m_run ? m_cyc + 1 : 0;
    m_t = nt; m_fv = nfv;
    m_run = nrun; m_frz = nfrz; m_exp = nexp; m_ovf = novf;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    start_p = 0; stop_p = 0; split_p = 0;
    clear_p = 0; load_p = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cycle();
    cycle();
    checks++;
    if (time_bcd !== 32'd0) begin errors++;
      $display("FAIL rst_time got %h want 0", time_bcd); end
    checks++;
    if (disp_bcd !== 32'd0) begin errors++;
      $display("FAIL rst_disp got %h want 0", disp_bcd); end
    checks++;
    if ({running, frozen, expired, lap_ovf} !== 4'b0) begin errors++;
      $display("FAIL rst_flags got %b want 0000",
               {running, frozen, expired, lap_ovf}); end
    checks++;
    if (lap_count !== '0) begin errors++;
      $display("FAIL rst_lapc got %0d want 0", lap_count); end
    reset = 0;
    cycle();
  endtask

  task automatic test_count_up();
    mode_down = 0;
    start_p = 1;
    cycle();
    checks++;
    if (running !== 1'b1) begin errors++;
      $display("FAIL start_lat running got %b want 1", running); end
    repeat (6000) cycle();
    stop_p = 1;
    cycle();
    checks++;
    if (running !== 1'b0) begin errors++;
      $display("FAIL stop_lat running got %b want 0", running); end
    checks++;
    if (time_bcd !== 32'h00000600) begin errors++;
      $display("FAIL up_6s got %h want 00000600", time_bcd); end
  endtask

  task automatic test_wrap();
    load_bcd = 24'h995959;
    load_p = 1;
    cycle();
    checks++;
    if (time_bcd !== 32'h99595900) begin errors++;
      $display("FAIL load_max got %h want 99595900", time_bcd); end
    start_p = 1;
    cycle();
    repeat (999) cycle();
    checks++;
    if (time_bcd !== 32'h99595999) begin errors++;
      $display("FAIL pre_wrap got %h want 99595999", time_bcd); end
    cycle();
    checks++;
    if (time_bcd !== 32'd0 || running !== 1'b1) begin errors++;
      $display("FAIL wrap got %h run %b want 0 run 1",
               time_bcd, running); end
    stop_p = 1;
    cycle();
  endtask

  task automatic test_countdown();
    mode_down = 1;
    load_bcd = 24'h000001;
    load_p = 1;
    cycle();
    start_p = 1;
    cycle();
    repeat (999) cycle();
    checks++;
    if (time_bcd !== 32'h00000001 || running !== 1'b1) begin errors++;
      $display("FAIL down_pre got %h run %b want 00000001 run 1",
               time_bcd, running); end
    cycle();
    checks++;
    if ({time_bcd, running, expired} !== {32'd0, 2'b01}) begin
      errors++;
      $display("FAIL expire got %h run %b exp %b want 0 run 0 exp 1",
               time_bcd, running, expired); end
    start_p = 1;
    cycle();
    checks++;
    if (running !== 1'b0) begin errors++;
      $display("FAIL start_zero running got %b want 0", running); end
    load_p = 1;
    cycle();
    checks++;
    if (expired !== 1'b0 || time_bcd !== 32'h00000100) begin
      errors++;
      $display("FAIL load_clr_exp got %h exp %b want 00000100 exp 0",
               time_bcd, expired); end
    mode_down = 0;
  endtask

  task automatic test_laps();
    int exp_lap[5];
    logic [31:0] held;
    clear_p = 1;
    cycle();
    start_p = 1;
    cycle();
    repeat ($urandom_range(20, 60)) cycle();
    for (int p = 0; p < 5; p++) begin
      exp_lap[p] = m_t;
      split_p = 1;
      cycle();
      held = to_bcd(exp_lap[p]);
      checks++;
      if (frozen !== 1'b1 || disp_bcd !== held) begin errors++;
        $display("FAIL freeze%0d frz %b disp %h want 1 %h",
                 p, frozen, disp_bcd, held); end
      repeat ($urandom_range(15, 40)) cycle();
      checks++;
      if (disp_bcd !== held || time_bcd !== to_bcd(m_t)) begin
        errors++;
        $display("FAIL hold%0d disp %h time %h want %h %h",
                 p, disp_bcd, time_bcd, held, to_bcd(m_t)); end
      split_p = 1;
      cycle();
      checks++;
      if (frozen !== 1'b0) begin errors++;
        $display("FAIL unfreeze%0d frozen got %b want 0", p, frozen); end
      repeat ($urandom_range(5, 30)) cycle();
    end
    checks++;
    if (lap_count !== 3'd4 || lap_ovf !== 1'b1) begin errors++;
      $display("FAIL lap_full cnt %0d ovf %b want 4 1",
               lap_count, lap_ovf); end
    for (int i = 0; i < 4; i++) begin
      lap_rd_idx = AW'(i);
      #1;
      checks++;
      if (lap_rd_data !== to_bcd(exp_lap[i])) begin errors++;
        $display("FAIL lap%0d got %h want %h",
                 i, lap_rd_data, to_bcd(exp_lap[i])); end
    end
    stop_p = 1;
    cycle();
  endtask

  task automatic test_priority();
    logic [31:0] snap;
    clear_p = 1;
    cycle();
    start_p = 1;
    cycle();
    repeat (25) cycle();
    stop_p = 1;
    start_p = 1;
    cycle();
    checks++;
    if (running !== 1'b0) begin errors++;
      $display("FAIL stop_beats_start running got %b want 0", running); end
    start_p = 1;
    cycle();
    load_bcd = 24'h123456;
    load_p = 1;
    cycle();
    checks++;
    if (time_bcd !== to_bcd(m_t) || time_bcd[31:8] === 24'h123456) begin
      errors++;
      $display("FAIL load_running got %h want %h",
               time_bcd, to_bcd(m_t)); end
    stop_p = 1;
    cycle();
    snap = to_bcd(m_t);
    load_bcd = 24'h006000;
    load_p = 1;
    cycle();
    checks++;
    if (time_bcd !== snap) begin errors++;
      $display("FAIL load_illegal got %h want %h", time_bcd, snap); end
  endtask

  task automatic test_reset_mid();
    clear_p = 1;
    cycle();
    start_p = 1;
    cycle();
    repeat (30) cycle();
    split_p = 1; cycle();
    repeat (20) cycle();
    split_p = 1; cycle();
    repeat (20) cycle();
    split_p = 1; cycle();
    repeat (15) cycle();
    checks++;
    if (frozen !== 1'b1 || lap_count !== 3'd2) begin errors++;
      $display("FAIL mid_setup frz %b cnt %0d want 1 2",
               frozen, lap_count); end
    reset = 1;
    cycle();
    checks++;
    if ({time_bcd, disp_bcd} !== 64'd0
        || {running, frozen, expired, lap_ovf} !== 4'b0
        || lap_count !== '0) begin
      errors++;
      $display("FAIL mid_reset time %h disp %h flags %b cnt %0d want 0",
               time_bcd, disp_bcd,
               {running, frozen, expired, lap_ovf}, lap_count); end
    for (int i = 0; i < 4; i++) begin
      lap_rd_idx = AW'(i);
      #1;
      checks++;
      if (lap_rd_data !== 32'd0) begin errors++;
        $display("FAIL mid_rd%0d got %h want 0", i, lap_rd_data); end
    end
    reset = 0;
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] exp_rd;
    for (int n = 0; n < 4000; n++) begin
      start_p = ($urandom_range(0, 99) < 6);
      stop_p  = ($urandom_range(0, 99) < 3);
      split_p = ($urandom_range(0, 99) < 6);
      clear_p = ($urandom_range(0, 199) < 1);
      load_p  = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 2)
        mode_down = ~mode_down;
      if ($urandom_range(0, 1) == 0)
        load_bcd = {16'h0000, 4'($urandom_range(0, 5)),
                    4'($urandom_range(0, 9))};
      else
        load_bcd = 24'($urandom);
      lap_rd_idx = AW'($urandom_range(0, 3));
      cycle();
      exp_rd = (int'(lap_rd_idx) < m_laps.size())
               ? to_bcd(m_laps[lap_rd_idx]) : 32'd0;
      checks++;
      if (time_bcd !== to_bcd(m_t)
          || disp_bcd !== (m_frz ? to_bcd(m_fv) : to_bcd(m_t))
          || {running, frozen, expired, lap_ovf}
             !== {m_run, m_frz, m_exp, m_ovf}
          || int'(lap_count) != m_laps.size()
          || lap_rd_data !== exp_rd) begin
        errors++;
        $display("FAIL rand%0d time %h disp %h fl %b cnt %0d rd %h want %h %h %b %0d %h",
                 n, time_bcd, disp_bcd,
                 {running, frozen, expired, lap_ovf}, lap_count,
                 lap_rd_data, to_bcd(m_t),
                 m_frz ? to_bcd(m_fv) : to_bcd(m_t),
                 {m_run, m_frz, m_exp, m_ovf}, m_laps.size(), exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_countdown();
    test_laps();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Parametrised stopwatch/timer engine replacing the fixed mm:ss counter used by the board top.
- Counts in 10 ms resolution over an hh:mm:ss.cc range, either up (stopwatch) or down (countdown timer).
- Supports split-freeze display, a lap capture buffer, and preset load.
- Sits between the debounced button pulses and the BCD seven-segment driver; purely synchronous to clk.

Parameters:
CLK_HZ, 100000000, input clock frequency; CLK_HZ/100 must be an integer ≥ 2.
LAP_DEPTH, 4, lap buffer entries; power of two, 2..16.

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
start_p  input  1  single-cycle start pulse
stop_p  input  1  single-cycle stop pulse
split_p  input  1  single-cycle split/lap pulse
clear_p  input  1  single-cycle clear pulse
mode_down  input  1  0 = count up, 1 = count down
load_p  input  1  single-cycle preset load pulse
load_bcd  input  24  preset value {hr_t,hr_o,min_t,min_o,sec_t,sec_o}
time_bcd  output  32  live time {hr_t,hr_o,min_t,min_o,sec_t,sec_o,cs_t,cs_o}
disp_bcd  output  32  display value: time_bcd, or the frozen split when frozen=1
running  output  1  counter active
frozen  output  1  display frozen at split
expired  output  1  countdown reached zero (sticky)
lap_count  output  $clog2(LAP_DEPTH)+1  number of stored laps
lap_ovf  output  1  sticky: a lap was dropped because the buffer was full
lap_rd_idx  input  $clog2(LAP_DEPTH)  lap read index; 0 = oldest
lap_rd_data  output  32  stored lap at lap_rd_idx; combinational read, 0 if idx ≥ lap_count

Behaviour:
- Reset: all outputs 0. Time 00:00:00.00, prescaler 0, lap buffer empty.
- Prescaler:
  - Counts 0..CLK_HZ/100-1 only while running.
  - tick = running & prescaler at terminal count.
  - Forced to 0 whenever running=0, so the first tick arrives exactly CLK_HZ/100 cycles after running rises.
- Up count on tick: BCD carry chain cs 00-99, sec 00-59, min 00-59, hr 00-99. 99:59:59.99 wraps to all-zero; running stays 1.
- Down count on tick: BCD borrow chain with the same limits.
  - The tick that reaches 00:00:00.00 also clears running and sets expired.
  - expired is cleared only by clear_p, a successful load_p, or reset.
- Command priority per cycle: reset > clear_p > load_p > stop_p > start_p > split_p. Lower-priority pulses in the same cycle are ignored.
- start_p: running←1 next cycle. Ignored if mode_down=1 and time is zero. Ignored if already running.
- stop_p: running←0 next cycle. A tick occurring in that same cycle is still applied.
- clear_p: time←0, running←0, frozen←0, expired←0, lap_count←0, lap_ovf←0.
- load_p:
  - Accepted only when running=0 and every load_bcd digit is legal (hr digits ≤9; min/sec tens ≤5, ones ≤9).
  - On accept: time←{load_bcd,8'h00}, expired←0.
  - Otherwise ignored with no state change.
- split_p, running=1 and frozen=0:
  - Freeze register←current time_bcd, frozen←1.
  - Same value appended to the lap buffer.
  - If lap_count==LAP_DEPTH, the entry is dropped and lap_ovf←1.
- split_p with frozen=1: frozen←0; no lap stored. Allowed even when stopped.
- split_p with running=0 and frozen=0: ignored.
- mode_down changes take effect at the next tick. A live time value is never reinterpreted.
- All outputs are registered, except disp_bcd (mux) and lap_rd_data (buffer read).
- Command-to-output latency is 1 cycle.

Test Plan:
- CLK_HZ=1000 (10 clk/tick): reset, start_p, run 6000 cycles, stop_p → time_bcd=32'h00000600; running=0 one cycle after stop_p.
- Load 99:59:59 (load_bcd=24'h995959), start up, 100 ticks → wraps through 99:59:59.99 to 32'h00000000; running stays 1.
- mode_down=1, load 24'h000001, start → after 100 ticks time=0, running=0, expired=1; a further start_p is ignored; load_p clears expired.
- LAP_DEPTH=4, running, issue 5 freeze/unfreeze split pairs → lap_count=4, lap_ovf=1; entries 0..3 hold the first four split times in order; disp_bcd holds while frozen.
- Same-cycle stop_p+start_p while running → stops. load_p while running → ignored. load_bcd=24'h006000 → ignored.
- Assert reset mid-count while frozen with 2 laps stored → all outputs 0 on the next cycle; lap_rd_data=0 for every idx.
